// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : UART receiver (8N1 style, configurable parity/stop bits)
//               feeding a first-word-fall-through receive FIFO with sticky
//               overflow and error-indication flags.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          io_rx,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow,
    input  logic                          clr_err,
    output logic                          indication
);

    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam int c_AW    = $clog2(FIFO_DEPTH);

    localparam logic [c_CNT_W-1:0] c_HALF      = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_FULL      = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]         c_LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic               c_STOP_LAST = (STOP_BITS == 2);
    localparam logic [c_AW:0]      c_DEPTH     = (c_AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 r_state;
    logic [1:0]             r_sync;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [3:0]             r_bit_idx;
    logic                   r_stop_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par_bad;
    logic                   r_stop_bad;
    logic                   r_push;

    logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]        r_wr_ptr;
    logic [c_AW-1:0]        r_rd_ptr;
    logic [c_AW:0]          r_count;

    logic                   w_rx;
    logic                   w_par_exp;
    logic                   w_pop;
    logic                   w_push_ok;
    logic                   w_ovf_evt;

    assign w_rx      = r_sync[1];
    assign w_par_exp = (PARITY_MODE == 2) ? ~^r_shift : ^r_shift;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], io_rx};
        end
    end

    // Receiver: every sample is taken at the bit mid-point located by START.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_shift    <= '0;
            r_par_bad  <= 1'b0;
            r_stop_bad <= 1'b0;
            r_push     <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            r_push     <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (!w_rx) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_cnt == c_HALF) begin
                        r_cnt <= '0;
                        if (w_rx) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state    <= S_DATA;
                            r_bit_idx  <= '0;
                            r_stop_idx <= 1'b0;
                            r_par_bad  <= 1'b0;
                            r_stop_bad <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == c_FULL) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_rx, r_shift[DATA_BITS-1:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == c_LAST_BIT) begin
                            r_state <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (r_cnt == c_FULL) begin
                        r_cnt   <= '0;
                        r_state <= S_STOP;
                        if (w_rx != w_par_exp) begin
                            parity_err <= 1'b1;
                            r_par_bad  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_cnt == c_FULL) begin
                        r_cnt <= '0;
                        // Only the first bad stop bit of a frame is reported.
                        if (!w_rx && !r_stop_bad) begin
                            frame_err  <= 1'b1;
                            r_stop_bad <= 1'b1;
                        end
                        if (r_stop_idx == c_STOP_LAST) begin
                            r_state <= S_IDLE;
                            r_push  <= !r_par_bad && !r_stop_bad && w_rx;
                        end else begin
                            r_stop_idx <= r_stop_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // A push into a full FIFO still succeeds when a pop frees the slot.
    assign rx_valid   = (r_count != '0);
    assign w_pop      = rx_valid && rx_ready;
    assign w_push_ok  = r_push && ((r_count != c_DEPTH) || w_pop);
    assign w_ovf_evt  = r_push && !w_push_ok;
    assign rx_data    = rx_valid ? r_mem[r_rd_ptr] : '0;
    assign fifo_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Error events win over a coincident clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow   <= 1'b0;
            indication <= 1'b0;
        end else begin
            if (w_ovf_evt) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (parity_err || frame_err || w_ovf_evt) begin
                indication <= 1'b1;
            end else if (clr_err) begin
                indication <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Self-checking bench for uart_rx_fifo (16 clk/bit, 8E1, depth 4)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       io_rx;
    logic       rx_ready;
    logic       clr_err;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [2:0] fifo_count;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;
    logic       indication;

    int n_total = 0;
    int n_bad   = 0;
    int n_perr  = 0;
    int n_ferr  = 0;

    uart_rx_fifo #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8),
        .PARITY_MODE  (1),
        .STOP_BITS    (1),
        .FIFO_DEPTH   (DEPTH)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .io_rx      (io_rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .fifo_count (fifo_count),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .clr_err    (clr_err),
        .indication (indication)
    );

    always #5 clk = ~clk;

    // Counting high cycles makes a stretched pulse show up as a count error.
    always @(negedge clk) begin
        if (parity_err === 1'b1) n_perr++;
        if (frame_err === 1'b1)  n_ferr++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        io_rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    // Even parity: parity bit makes the total count of ones even.
    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_v);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit((^d) ^ par_flip);
        send_bit(stop_v);
        io_rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        int t;
        t = 0;
        while (rx_valid !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_val({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
        check_val({tag, "_data"}, {24'd0, rx_data}, {24'd0, exp});
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_valid"}, {31'd0, rx_valid}, 32'd0);
        check_val({tag, "_count"}, {29'd0, fifo_count}, 32'd0);
        check_val({tag, "_data"}, {24'd0, rx_data}, 32'd0);
        check_val({tag, "_flags"}, {28'd0, parity_err, frame_err, overflow, indication}, 32'd0);
    endtask

    initial begin
        int         p0, f0, npop, kind;
        logic [7:0] d;
        logic [7:0] exp_q[$];
        logic       exp_ovf, exp_ind, ok;

        reset    = 1'b1;
        io_rx    = 1'b1;
        rx_ready = 1'b0;
        clr_err  = 1'b0;
        repeat (4) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        repeat (2 * CPB) @(negedge clk);

        // Good frame held in FIFO
        p0 = n_perr; f0 = n_ferr;
        send_frame(8'hA5, 1'b0, 1'b1);
        check_val("good_data", {24'd0, rx_data}, 32'hA5);
        check_val("good_valid", {31'd0, rx_valid}, 32'd1);
        check_val("good_count", {29'd0, fifo_count}, 32'd1);
        check_val("good_pulses", n_perr - p0 + n_ferr - f0, 0);
        pop_check("good_pop", 8'hA5);
        check_val("good_empty", {29'd0, fifo_count}, 32'd0);

        // Parity error
        p0 = n_perr;
        send_frame(8'hA5, 1'b1, 1'b1);
        check_val("par_pulse", n_perr - p0, 1);
        check_val("par_count", {29'd0, fifo_count}, 32'd0);
        check_val("par_ind", {31'd0, indication}, 32'd1);
        pulse_clr();
        check_val("par_clr", {31'd0, indication}, 32'd0);

        // Short glitch on the line
        p0 = n_perr; f0 = n_ferr;
        io_rx = 1'b0;
        repeat (4) @(negedge clk);
        io_rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check_val("glitch_count", {29'd0, fifo_count}, 32'd0);
        check_val("glitch_pulses", n_perr - p0 + n_ferr - f0, 0);
        check_val("glitch_ind", {31'd0, indication}, 32'd0);

        // Framing error, then a clean frame
        f0 = n_ferr;
        send_frame(8'h3C, 1'b0, 1'b0);
        check_val("frm_pulse", n_ferr - f0, 1);
        check_val("frm_count", {29'd0, fifo_count}, 32'd0);
        check_val("frm_ind", {31'd0, indication}, 32'd1);
        send_frame(8'h3C, 1'b0, 1'b1);
        check_val("frm_next_count", {29'd0, fifo_count}, 32'd1);
        pop_check("frm_next", 8'h3C);
        pulse_clr();

        // Overflow
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b1);
        check_val("ovf_count", {29'd0, fifo_count}, 32'd4);
        check_val("ovf_flag", {31'd0, overflow}, 32'd1);
        check_val("ovf_ind", {31'd0, indication}, 32'd1);
        for (int i = 1; i <= 4; i++) pop_check("ovf_pop", 8'(i));
        check_val("ovf_drained", {31'd0, rx_valid}, 32'd0);
        pulse_clr();
        check_val("ovf_clr", {30'd0, overflow, indication}, 32'd0);

        // Reset in the middle of data bit 3
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b1, 1'b1);
        check_val("pre_rst_state", {28'd0, indication, fifo_count}, 32'h9);
        fork
            send_frame(8'h77, 1'b0, 1'b1);
            begin
                repeat (4 * CPB + CPB / 2) @(negedge clk);
                reset = 1'b1;
                repeat (2) @(negedge clk);
                check_idle_outputs("midrst");
                repeat (7 * CPB) @(negedge clk);
                reset = 1'b0;
            end
        join
        check_idle_outputs("post_rst");
        send_frame(8'h5A, 1'b0, 1'b1);
        check_val("post_rst_count", {29'd0, fifo_count}, 32'd1);
        pop_check("post_rst", 8'h5A);

        // Randomized frames against a queue model
        exp_ovf = 1'b0;
        exp_ind = 1'b0;
        for (int n = 0; n < 24; n++) begin
            kind = $urandom_range(0, 9);
            d    = 8'($urandom);
            p0 = n_perr; f0 = n_ferr;
            send_frame(d, kind == 8, kind != 9);
            ok = (kind < 8);
            if (ok) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(d);
                else begin
                    exp_ovf = 1'b1;
                    exp_ind = 1'b1;
                end
            end else begin
                exp_ind = 1'b1;
            end
            check_val("rnd_perr", n_perr - p0, (kind == 8) ? 1 : 0);
            check_val("rnd_ferr", n_ferr - f0, (kind == 9) ? 1 : 0);
            check_val("rnd_count", {29'd0, fifo_count}, exp_q.size());
            check_val("rnd_flags", {30'd0, overflow, indication}, {30'd0, exp_ovf, exp_ind});
            npop = $urandom_range(0, exp_q.size());
            for (int k = 0; k < npop; k++) pop_check("rnd_pop", exp_q.pop_front());
            if ($urandom_range(0, 3) == 0) begin
                pulse_clr();
                exp_ovf = 1'b0;
                exp_ind = 1'b0;
            end
        end
        while (exp_q.size() > 0) pop_check("rnd_drain", exp_q.pop_front());
        check_val("rnd_end_valid", {31'd0, rx_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
